isp1362_bus_bridge: RTL
=======================

ISP1362_BUS_BRIDGE -- requirements
Module: isp1362_bus_bridge

Interface
REQ-001 Parameters SHALL be: NUM_CH, 2, number of Avalon-MM slave channels (1..4); DATA_W, 16, data width; ADDR_W, 1, per-channel address width; SETUP_CYC, 1, address/CS setup cycles before strobe (1..15); STROBE_CYC, 3, RD_N/WR_N low cycles (1..15); HOLD_CYC, 1, cycles after strobe release (1..15).
REQ-002 iCLK input 1: single clock; iRST_N input 1: reset, synchronous, active-low.
REQ-003 avs_address_iADDR input NUM_CH*ADDR_W: per-channel address, channel i at slice i.
REQ-004 avs_writedata_iDATA input NUM_CH*DATA_W: per-channel write data.
REQ-005 avs_readdata_oDATA output NUM_CH*DATA_W: per-channel registered read data.
REQ-006 avs_read_n_iRD_N, avs_write_n_iWR_N, avs_chipselect_n_iCS_N input NUM_CH each: per-channel active-low strobes.
REQ-007 avs_waitrequest_oWAIT output NUM_CH: per-channel Avalon wait request.
REQ-008 avs_irq_n_oINT_N output NUM_CH: per-channel interrupt, active-low.
REQ-009 USB_DATA inout DATA_W; USB_ADDR output ADDR_W+clog2(NUM_CH) ({channel, address}); USB_RD_N, USB_WR_N, USB_CS_N, USB_RST_N outputs 1; USB_INT input NUM_CH.

Function
REQ-010 Channel i requests when CS_N[i]=0 and (RD_N[i]=0 or WR_N[i]=0); WR_N and RD_N both low SHALL execute a write.
REQ-011 FSM states IDLE, SETUP, STROBE, HOLD, DONE; IDLE->SETUP on any request, SETUP->STROBE after SETUP_CYC, STROBE->HOLD after STROBE_CYC, HOLD->DONE after HOLD_CYC, DONE->IDLE unconditionally.
REQ-012 Grant SHALL be round-robin, starting search at channel after last granted; index, address, data, direction latched on IDLE->SETUP.
REQ-013 USB_CS_N and USB_ADDR registered, valid from SETUP through HOLD; USB_RD_N/USB_WR_N low only in STROBE.
REQ-014 USB_DATA SHALL be driven with latched write data SETUP through HOLD of writes only; otherwise high-impedance.
REQ-015 Read data SHALL be captured from USB_DATA on final STROBE cycle into avs_readdata_oDATA of granted channel; other channels' readdata unchanged.
REQ-016 avs_waitrequest_oWAIT[i] SHALL be 1 while channel i requests, except exactly in DONE with grant=i (combinational).
REQ-017 Access latency request-to-waitrequest-low SHALL be 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles when bus idle.
REQ-018 Request withdrawn mid-transaction: bus cycle SHALL complete unchanged; no retry.
REQ-019 Requests arriving during non-IDLE states SHALL wait; none lost, none duplicated.
REQ-020 Phase counter SHALL be 4 bits, reloaded per state, never wrapping.
REQ-021 avs_irq_n_oINT_N[i] SHALL follow USB_INT[i] (see Configuration).

Reset
REQ-022 iRST_N=0 at clock edge: state IDLE, USB_CS_N/RD_N/WR_N=1, USB_DATA high-Z, USB_ADDR=0, readdata=0, round-robin pointer=NUM_CH-1.
REQ-023 USB_RST_N SHALL be a registered copy of iRST_N (0 during reset, 1 one cycle after release).
REQ-024 Reset mid-transaction SHALL abort immediately; no DONE cycle issued.

Configuration
REQ-025 Macro ISP1362_IRQ_SYNC_EN defined: USB_INT passes a two-flop synchronizer (reset to 1), 2-cycle latency; undefined: combinational passthrough.

Structure
REQ-026 Package isp1362_bridge_pkg SHALL hold FSM state enum, default timing constants, counter width.
REQ-027 Round-robin grant SHALL be sub-module isp1362_rr_arbiter (request vector, last-grant in, grant index out).

Verification
REQ-028 Ch0 write addr 1 data 16'hA5C3 -> USB_ADDR=2'b01, WR_N low 3 cycles, USB_DATA=16'hA5C3 SETUP..HOLD, waitrequest low at cycle 6.
REQ-029 Ch1 read addr 0, USB_DATA model 16'h1234 -> USB_ADDR=2'b10, readdata[1]=16'h1234, readdata[0] unchanged.
REQ-030 Ch0 and ch1 request same cycle after reset -> ch0 served first, ch1 second; repeated dual requests alternate.
REQ-031 iRST_N low during STROBE -> next edge all strobes 1, USB_DATA high-Z, no waitrequest release, USB_RST_N=0.
REQ-032 USB_INT[1] pulse 0 -> irq_n[1] follows after 2 cycles with ISP1362_IRQ_SYNC_EN, same cycle without.
REQ-033 Ch0 deasserts CS_N during SETUP -> full bus cycle completes, FSM returns IDLE, no ack to ch0.

Source files
------------

// File: rtl/isp1362_bridge_pkg.sv
// ============================================================================
// Module   : isp1362_bridge_pkg
// Purpose  : Shared FSM state encoding and default bus timing for the
//            ISP1362 Avalon-to-host-bus bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

package isp1362_bridge_pkg;

  localparam int CNT_W          = 4;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 3;
  localparam int DEF_HOLD_CYC   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } bus_state_e;

  // Counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] phase_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/isp1362_rr_arbiter.sv
// ============================================================================
// Module   : isp1362_rr_arbiter
// Purpose  : Combinational round-robin pick; search begins at the channel
//            after the last granted one.
// Revision : 1.0
// ============================================================================
`default_nettype none

module isp1362_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_last_grant,
  output logic [IDX_W-1:0]  o_grant,
  output logic              o_valid
);

  logic [IDX_W-1:0] idx;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_grant = i_last_grant;
    o_valid = 1'b0;
    idx     = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = IDX_W'((int'(i_last_grant) + k) % NUM_CH);
      if (i_req[idx]) begin
        o_grant = idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/isp1362_bus_bridge.sv
// ============================================================================
// Module   : isp1362_bus_bridge
// Purpose  : Multi-channel Avalon-MM slave to ISP1362 asynchronous host bus,
//            with programmable setup/strobe/hold timing. Define
//            ISP1362_IRQ_SYNC_EN to pass USB_INT through a 2-flop synchronizer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module isp1362_bus_bridge
  import isp1362_bridge_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 1,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic                              iCLK,
  input  logic                              iRST_N,
  input  logic [NUM_CH*ADDR_W-1:0]          avs_address_iADDR,
  input  logic [NUM_CH*DATA_W-1:0]          avs_writedata_iDATA,
  output logic [NUM_CH*DATA_W-1:0]          avs_readdata_oDATA,
  input  logic [NUM_CH-1:0]                 avs_read_n_iRD_N,
  input  logic [NUM_CH-1:0]                 avs_write_n_iWR_N,
  input  logic [NUM_CH-1:0]                 avs_chipselect_n_iCS_N,
  output logic [NUM_CH-1:0]                 avs_waitrequest_oWAIT,
  output logic [NUM_CH-1:0]                 avs_irq_n_oINT_N,
  inout  wire  [DATA_W-1:0]                 USB_DATA,
  output logic [ADDR_W+$clog2(NUM_CH)-1:0]  USB_ADDR,
  output logic                              USB_RD_N,
  output logic                              USB_WR_N,
  output logic                              USB_CS_N,
  output logic                              USB_RST_N,
  input  logic [NUM_CH-1:0]                 USB_INT
);

  localparam int CH_BITS = $clog2(NUM_CH);
  localparam int IDX_W   = (NUM_CH > 1) ? CH_BITS : 1;
  localparam int UA_W    = ADDR_W + CH_BITS;

  bus_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          gnt_q, gnt_d, last_q, last_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic                      wr_q, wr_d;
  logic                      cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic                      oe_q, oe_d;
  logic                      usb_rst_n_q, usb_rst_n_d;
  logic [UA_W-1:0]           uaddr_q, uaddr_d;
  logic [NUM_CH*DATA_W-1:0]  rdata_q, rdata_d;

  logic [NUM_CH-1:0]         req;
  logic [IDX_W-1:0]          arb_gnt;
  logic                      arb_valid;
  logic [ADDR_W-1:0]         arb_addr;
  logic [UA_W-1:0]           arb_uaddr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign req[i] = ~avs_chipselect_n_iCS_N[i] &
                    (~avs_read_n_iRD_N[i] | ~avs_write_n_iWR_N[i]);
    assign avs_waitrequest_oWAIT[i] = req[i] &
                    ~((state_q == ST_DONE) && (gnt_q == IDX_W'(i)));
  end

  isp1362_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .i_req        (req),
    .i_last_grant (last_q),
    .o_grant      (arb_gnt),
    .o_valid      (arb_valid)
  );

  assign arb_addr = avs_address_iADDR[int'(arb_gnt)*ADDR_W +: ADDR_W];

  if (NUM_CH > 1) begin : g_addr_multi
    assign arb_uaddr = {arb_gnt, arb_addr};
  end else begin : g_addr_single
    assign arb_uaddr = arb_addr;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    uaddr_d     = uaddr_q;
    rdata_d     = rdata_q;
    usb_rst_n_d = iRST_N;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_SETUP;
          cnt_d   = phase_load(SETUP_CYC);
          gnt_d   = arb_gnt;
          last_d  = arb_gnt;
          uaddr_d = arb_uaddr;
          wdata_d = avs_writedata_iDATA[int'(arb_gnt)*DATA_W +: DATA_W];
          wr_d    = ~avs_write_n_iWR_N[arb_gnt];
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = phase_load(STROBE_CYC);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = phase_load(HOLD_CYC);
          if (!wr_q) begin
            rdata_d[int'(gnt_q)*DATA_W +: DATA_W] = USB_DATA;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus pins are registered from the next state so they line up with it.
    cs_n_d = ~(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
    rd_n_d = ~((state_d == ST_STROBE) && !wr_d);
    wr_n_d = ~((state_d == ST_STROBE) && wr_d);
    oe_d   = wr_d && !cs_n_d;
  end

  always_ff @(posedge iCLK) begin
    usb_rst_n_q <= usb_rst_n_d;
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_CH - 1);
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      uaddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
      uaddr_q <= uaddr_d;
      rdata_q <= rdata_d;
    end
  end

  assign USB_DATA           = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign USB_ADDR           = uaddr_q;
  assign USB_CS_N           = cs_n_q;
  assign USB_RD_N           = rd_n_q;
  assign USB_WR_N           = wr_n_q;
  assign USB_RST_N          = usb_rst_n_q;
  assign avs_readdata_oDATA = rdata_q;

`ifdef ISP1362_IRQ_SYNC_EN
  logic [NUM_CH-1:0] irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d;

  always_comb begin
    irq_s1_d = USB_INT;
    irq_s2_d = irq_s1_q;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      irq_s1_q <= '1;
      irq_s2_q <= '1;
    end else begin
      irq_s1_q <= irq_s1_d;
      irq_s2_q <= irq_s2_d;
    end
  end

  assign avs_irq_n_oINT_N = irq_s2_q;
`else
  assign avs_irq_n_oINT_N = USB_INT;
`endif

endmodule

`default_nettype wire
